// File: rtl/hnf_pocq_admit.sv
// Admission control for the HN-F POCQ: admits, retries or reserves slots and issues PCrdGrant round-robin.
// pocq_push_en is zero latency; retry_v, pcrd_v and the counters are registered one cycle after the request or release.
// The pcrd_v/pcrd_tgt grant is held until pcrd_ready; requests cannot be stalled and are either pushed or answered with RetryAck.
module hnf_pocq_admit #(
   parameter  int DEPTH  = 16,
   parameter  int NUM_RN = 4,
   parameter  int CNT_W  = 4,
   localparam int SW     = (NUM_RN > 1) ? $clog2(NUM_RN) : 1,
   localparam int OW     = $clog2(DEPTH + 1)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          req_v,
   input  logic [SW-1:0] req_src,
   input  logic          req_allow_retry,
   input  logic          release_v,
   output logic          pocq_push_en,
   output logic          retry_v,
   output logic [SW-1:0] retry_tgt,
   output logic          pcrd_v,
   output logic [SW-1:0] pcrd_tgt,
   input  logic          pcrd_ready,
   output logic [OW-1:0] occupancy,
   output logic          full,
   output logic          err
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [OW-1:0]    ONE_O = OW'(1);
   localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
   localparam logic [OW:0]      DEPTH_V = (OW + 1)'(DEPTH);

   state_t           state;
   logic [OW-1:0]    occ;
   logic [OW-1:0]    reserved_total;
   logic [CNT_W-1:0] waiting  [NUM_RN];
   logic [CNT_W-1:0] reserved [NUM_RN];
   logic [SW-1:0]    rr_ptr;

   logic [OW:0]      free;
   logic             free_nz;
   logic             any_waiting;
   logic             gnt_found;
   logic [SW-1:0]    gnt_src;
   logic             fresh_admit;
   logic             fresh_reject;
   logic             wait_sat;
   logic             res_push;
   logic             res_err;
   logic             rel_ok;
   logic             rel_err;
   logic             do_grant;
   logic             wait_inc [NUM_RN];
   logic             wait_dec [NUM_RN];
   logic             res_inc  [NUM_RN];
   logic             res_dec  [NUM_RN];

   // Slots left after counting both allocated entries and outstanding reservations.
   assign free    = DEPTH_V - {1'b0, occ} - {1'b0, reserved_total};
   assign free_nz = (free != '0);

   // Round-robin pick of the next waiting requester, starting just after the last one granted.
   always_comb begin
      any_waiting = 1'b0;
      gnt_found   = 1'b0;
      gnt_src     = '0;
      for (int i = 0; i < NUM_RN; i++) begin
         if (waiting[i] != '0) any_waiting = 1'b1;
      end
      // Walk from the farthest offset inward so the nearest hit is the one kept.
      for (int i = NUM_RN; i >= 1; i--) begin
         int idx;
         idx = (int'(rr_ptr) + i) % NUM_RN;
         if (waiting[idx] != '0) begin
            gnt_found = 1'b1;
            gnt_src   = SW'(idx);
         end
      end
   end

   // Request classification; fresh admits are blocked while anyone is owed a credit so retried requesters keep priority.
   always_comb begin
      fresh_admit  = req_v &  req_allow_retry & free_nz & ~any_waiting;
      fresh_reject = req_v &  req_allow_retry & ~fresh_admit;
      wait_sat     = (waiting[req_src] == '1);
      res_push     = req_v & ~req_allow_retry & (reserved[req_src] != '0);
      res_err      = req_v & ~req_allow_retry & (reserved[req_src] == '0);
      rel_ok       = release_v & (occ != '0);
      rel_err      = release_v & (occ == '0);
      do_grant     = (state == IDLE) & free_nz & gnt_found;
      pocq_push_en = fresh_admit | res_push;
   end

   // Per-requester increment/decrement strobes; opposite strobes on one counter cancel.
   always_comb begin
      for (int i = 0; i < NUM_RN; i++) begin
         wait_inc[i] = fresh_reject & ~wait_sat & (int'(req_src) == i);
         wait_dec[i] = do_grant & (int'(gnt_src) == i);
         res_inc[i]  = do_grant & (int'(gnt_src) == i);
         res_dec[i]  = res_push & (int'(req_src) == i);
      end
   end

   // Occupancy, reservation and retry-debt counters plus the RetryAck pulse and sticky error.
   always_ff @(posedge clock) begin
      if (reset) begin
         occ            <= '0;
         reserved_total <= '0;
         retry_v        <= 1'b0;
         retry_tgt      <= '0;
         err            <= 1'b0;
         for (int i = 0; i < NUM_RN; i++) begin
            waiting[i]  <= '0;
            reserved[i] <= '0;
         end
      end else begin
         case ({pocq_push_en, rel_ok})
            2'b10:   occ <= occ + ONE_O;
            2'b01:   occ <= occ - ONE_O;
            default: occ <= occ;
         endcase
         case ({do_grant, res_push})
            2'b10:   reserved_total <= reserved_total + ONE_O;
            2'b01:   reserved_total <= reserved_total - ONE_O;
            default: reserved_total <= reserved_total;
         endcase
         retry_v <= fresh_reject;
         if (fresh_reject) retry_tgt <= req_src;
         if (res_err | rel_err | (fresh_reject & wait_sat)) err <= 1'b1;
         for (int i = 0; i < NUM_RN; i++) begin
            if (wait_inc[i] & ~wait_dec[i])      waiting[i] <= waiting[i] + ONE_C;
            else if (wait_dec[i] & ~wait_inc[i]) waiting[i] <= waiting[i] - ONE_C;
            if (res_inc[i] & ~res_dec[i])        reserved[i] <= reserved[i] + ONE_C;
            else if (res_dec[i] & ~res_inc[i])   reserved[i] <= reserved[i] - ONE_C;
         end
      end
   end

   // Grant FSM: load a credit in IDLE, hold it in GRANT until the RSP channel takes it.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         pcrd_v   <= 1'b0;
         pcrd_tgt <= '0;
         rr_ptr   <= SW'(NUM_RN - 1);
      end else begin
         case (state)
            IDLE: begin
               if (do_grant) begin
                  state    <= GRANT;
                  pcrd_v   <= 1'b1;
                  pcrd_tgt <= gnt_src;
                  rr_ptr   <= gnt_src;
               end
            end
            GRANT: begin
               if (pcrd_ready) begin
                  state  <= IDLE;
                  pcrd_v <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               pcrd_v <= 1'b0;
            end
         endcase
      end
   end

   assign occupancy = occ;
   assign full      = ~free_nz;

endmodule

// File: tb/tb_hnf_pocq_admit.sv
// Directed bench for hnf_pocq_admit with DEPTH=2, NUM_RN=2.
// Inputs change 1 time unit after a rising edge; outputs are sampled mid-cycle.
// Expected values are hand-derived for each step.
module tb_hnf_pocq_admit;

   logic       clock = 1'b0;
   logic       reset;
   logic       req_v;
   logic [0:0] req_src;
   logic       req_allow_retry;
   logic       release_v;
   logic       pocq_push_en;
   logic       retry_v;
   logic [0:0] retry_tgt;
   logic       pcrd_v;
   logic [0:0] pcrd_tgt;
   logic       pcrd_ready;
   logic [1:0] occupancy;
   logic       full;
   logic       err;

   int n_tests = 0;
   int n_fail  = 0;

   hnf_pocq_admit #(.DEPTH(2), .NUM_RN(2), .CNT_W(4)) dut (
      .clock           (clock),
      .reset           (reset),
      .req_v           (req_v),
      .req_src         (req_src),
      .req_allow_retry (req_allow_retry),
      .release_v       (release_v),
      .pocq_push_en    (pocq_push_en),
      .retry_v         (retry_v),
      .retry_tgt       (retry_tgt),
      .pcrd_v          (pcrd_v),
      .pcrd_tgt        (pcrd_tgt),
      .pcrd_ready      (pcrd_ready),
      .occupancy       (occupancy),
      .full            (full),
      .err             (err)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      req_v = 1'b0; req_src = 1'b0; req_allow_retry = 1'b0;
      release_v = 1'b0; pcrd_ready = 1'b0;
   endtask

   // Present a request and check the same-cycle push decision.
   task automatic send_req(input logic src, input logic ar, input logic exp_push, input string tag);
      req_v = 1'b1; req_src = src; req_allow_retry = ar;
      #1;
      check(tag, pocq_push_en, exp_push);
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      #1;
      check("rst_push", pocq_push_en, 0);
      check("rst_retry_v", retry_v, 0);
      check("rst_retry_tgt", retry_tgt, 0);
      check("rst_pcrd_v", pcrd_v, 0);
      check("rst_pcrd_tgt", pcrd_tgt, 0);
      check("rst_occ", occupancy, 0);
      check("rst_full", full, 0);
      check("rst_err", err, 0);

      // Fill the queue from src0.
      send_req(1'b0, 1'b1, 1'b1, "push0");
      tick();
      check("occ_1", occupancy, 1);
      send_req(1'b0, 1'b1, 1'b1, "push1");
      tick();
      idle_inputs();
      #1;
      check("occ_2", occupancy, 2);
      check("full_2", full, 1);

      // Third request from src1 must be retried.
      send_req(1'b1, 1'b1, 1'b0, "push_full");
      tick();
      idle_inputs();
      check("retry_v_1", retry_v, 1);
      check("retry_tgt_1", retry_tgt, 1);
      tick();
      check("retry_pulse_end", retry_v, 0);
      check("no_grant_full", pcrd_v, 0);

      // Release opens a slot; credit goes to src1 one cycle later.
      release_v = 1'b1;
      tick();
      release_v = 1'b0;
      check("rel_occ", occupancy, 1);
      check("rel_full", full, 0);
      tick();
      check("grant_v", pcrd_v, 1);
      check("grant_tgt", pcrd_tgt, 1);
      check("grant_full", full, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_v", pcrd_v, 1);
         check("hold_tgt", pcrd_tgt, 1);
      end
      pcrd_ready = 1'b1;
      tick();
      pcrd_ready = 1'b0;
      check("grant_done", pcrd_v, 0);

      // src1 re-sends into its reserved slot.
      send_req(1'b1, 1'b0, 1'b1, "resv_push");
      tick();
      idle_inputs();
      check("resv_occ", occupancy, 2);
      check("resv_err", err, 0);
      check("resv_full", full, 1);

      // src0 claims a reservation it does not own.
      send_req(1'b0, 1'b0, 1'b0, "bad_resv_push");
      tick();
      idle_inputs();
      check("bad_resv_retry", retry_v, 0);
      check("bad_resv_err", err, 1);
      check("bad_resv_occ", occupancy, 2);
      tick();
      check("err_sticky", err, 1);

      // Both requesters retried on a full queue.
      send_req(1'b0, 1'b1, 1'b0, "rr_rej0");
      tick();
      check("rr_retry0_v", retry_v, 1);
      check("rr_retry0_tgt", retry_tgt, 0);
      send_req(1'b1, 1'b1, 1'b0, "rr_rej1");
      tick();
      idle_inputs();
      check("rr_retry1_v", retry_v, 1);
      check("rr_retry1_tgt", retry_tgt, 1);

      release_v = 1'b1;
      tick();
      release_v = 1'b0;
      check("rr_rel1_occ", occupancy, 1);
      check("rr_no_grant_yet", pcrd_v, 0);
      // free = 1 but debt is outstanding: a fresh request still gets retried.
      send_req(1'b1, 1'b1, 1'b0, "fresh_blocked");
      tick();
      idle_inputs();
      check("fresh_retry_v", retry_v, 1);
      check("fresh_retry_tgt", retry_tgt, 1);
      check("rr_grant0_v", pcrd_v, 1);
      check("rr_grant0_tgt", pcrd_tgt, 0);
      check("rr_grant0_full", full, 1);
      pcrd_ready = 1'b1;
      tick();
      pcrd_ready = 1'b0;
      check("rr_grant0_done", pcrd_v, 0);

      release_v = 1'b1;
      tick();
      release_v = 1'b0;
      check("rr_rel2_occ", occupancy, 0);
      check("rr_rel2_no_grant", pcrd_v, 0);
      tick();
      check("rr_grant1_v", pcrd_v, 1);
      check("rr_grant1_tgt", pcrd_tgt, 1);
      pcrd_ready = 1'b1;
      tick();
      pcrd_ready = 1'b0;
      check("rr_grant1_done", pcrd_v, 0);
      check("rr_full_resv", full, 1);

      // Reset mid-operation discards reservations and debt.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_occ", occupancy, 0);
      check("mid_rst_full", full, 0);
      check("mid_rst_err", err, 0);
      check("mid_rst_pcrd", pcrd_v, 0);
      send_req(1'b1, 1'b1, 1'b1, "post_rst_push");
      tick();
      idle_inputs();
      check("post_rst_occ", occupancy, 1);
      check("post_rst_retry", retry_v, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
